// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared constants for the register-file sequencer: opcodes,
//                FSM state encoding and instruction field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Opcodes; 10..15 are illegal
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_LOADI = 4'd6;
    localparam logic [3:0] OP_MOV   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;

    // FSM state encoding
    localparam int         STATE_W  = 3;
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    // Instruction field slices
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Combinational 8-bit ALU for the register-file sequencer.
//                Also classifies the opcode (writes rd / sets flags / illegal).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] imm8,
    output logic [7:0] y,
    output logic       c,
    output logic       z,
    output logic       writes_rd,
    output logic       sets_flags,
    output logic       illegal
);

    logic [8:0] w_sum;

    // Opcode decode and datapath; every output defaults to the "no effect" value
    always_comb begin
        y          = 8'h00;
        c          = 1'b0;
        writes_rd  = 1'b0;
        sets_flags = 1'b0;
        illegal    = 1'b0;
        w_sum      = 9'h000;
        case (opcode)
            OP_NOP: begin
            end
            OP_ADD: begin
                w_sum      = {1'b0, a} + {1'b0, b};
                y          = w_sum[7:0];
                c          = w_sum[8];
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_SUB: begin
                y          = a - b;
                c          = (a < b);
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_AND: begin
                y          = a & b;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_OR: begin
                y          = a | b;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_XOR: begin
                y          = a ^ b;
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_LOADI: begin
                y          = imm8;
                writes_rd  = 1'b1;
            end
            OP_MOV: begin
                y          = a;
                writes_rd  = 1'b1;
            end
            OP_SHL: begin
                y          = {a[6:0], 1'b0};
                c          = a[7];
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            OP_SHR: begin
                y          = {1'b0, a[7:1]};
                c          = a[0];
                writes_rd  = 1'b1;
                sets_flags = 1'b1;
            end
            default: begin
                illegal    = 1'b1;
            end
        endcase
    end

    assign z = (y == 8'h00);

endmodule : seq_alu
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sequencer
//  Description : Multi-cycle controller owning a 16x8 register file with no
//                write enable. Clears the file after reset, then runs
//                READ -> EXEC -> WRITE for each accepted instruction. Every
//                cycle that is not a real write rewrites a register with its
//                own value so the always-writing file is left undisturbed.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer
    import seq_pkg::*;
#(
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  rf_A,
    input  logic [7:0]  rf_B,
    output logic [3:0]  rf_A_sel,
    output logic [3:0]  rf_B_sel,
    output logic [3:0]  rf_replaceSel,
    output logic [7:0]  rf_replaceData,
    output logic [7:0]  result,
    output logic        zero,
    output logic        carry,
    output logic        done,
    output logic        err,
    output logic        busy
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [3:0]         r_cnt;
    logic [15:0]        r_instr;
    logic [7:0]         r_op_a;
    logic [7:0]         r_op_b;
    logic [7:0]         r_result;
    logic               r_zero;
    logic               r_carry;
    logic [3:0]         r_a_sel;
    logic [3:0]         r_b_sel;

    logic [3:0]         w_opcode;
    logic [3:0]         w_rd;
    logic [7:0]         w_imm8;
    logic [7:0]         w_alu_y;
    logic               w_alu_c;
    logic               w_alu_z;
    logic               w_writes_rd;
    logic               w_sets_flags;
    logic               w_illegal;

    assign w_opcode = r_instr[OPC_MSB:OPC_LSB];
    assign w_rd     = r_instr[RD_MSB:RD_LSB];
    assign w_imm8   = r_instr[IMM_MSB:IMM_LSB];

    seq_alu u_alu (
        .opcode     (w_opcode),
        .a          (r_op_a),
        .b          (r_op_b),
        .imm8       (w_imm8),
        .y          (w_alu_y),
        .c          (w_alu_c),
        .z          (w_alu_z),
        .writes_rd  (w_writes_rd),
        .sets_flags (w_sets_flags),
        .illegal    (w_illegal)
    );

    // State register; reset from any state restarts the clearing sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sweep counter, instruction/operand capture, result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_instr  <= 16'h0000;
            r_op_a   <= 8'h00;
            r_op_b   <= 8'h00;
            r_result <= 8'h00;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_a_sel  <= 4'd0;
            r_b_sel  <= 4'd0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // Wraps back to 0 on leaving INIT
                    r_cnt <= r_cnt + 4'd1;
                end
                ST_IDLE: begin
                    if (instr_valid) begin
                        // Read selects are registered so they are valid for the whole READ cycle
                        r_instr <= instr;
                        r_a_sel <= instr[RA_MSB:RA_LSB];
                        r_b_sel <= instr[RB_MSB:RB_LSB];
                    end
                end
                ST_READ: begin
                    r_op_a <= rf_A;
                    r_op_b <= rf_B;
                end
                ST_EXEC: begin
                    if (w_writes_rd) begin
                        r_result <= w_alu_y;
                    end
                    if (w_sets_flags) begin
                        r_zero  <= w_alu_z;
                        r_carry <= w_alu_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic, handshake/status outputs and the write-port mux
    always_comb begin
        w_next_state   = r_state;
        instr_ready    = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        rf_replaceSel  = r_a_sel;
        rf_replaceData = rf_A;
        case (r_state)
            ST_INIT: begin
                rf_replaceSel  = r_cnt;
                rf_replaceData = INIT_VALUE;
                if (r_cnt == 4'd15) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                done = 1'b1;
                err  = w_illegal;
                if (w_writes_rd) begin
                    rf_replaceSel  = w_rd;
                    rf_replaceData = r_result;
                end
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    assign rf_A_sel = r_a_sel;
    assign rf_B_sel = r_b_sel;
    assign result   = r_result;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign busy     = (r_state != ST_IDLE);

endmodule : regfile_sequencer
`default_nettype wire

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multi-cycle controller that owns all ports of the 16×8 register file and executes a stream of 16-bit register-to-register instructions against it. It clears the file after reset, and accepts instructions over a valid/ready handshake. For each instruction it sequences operand read, ALU execute and write-back, and reports result, flags and completion. The register file has no write enable and writes `replaceData` to `regs[replaceSel]` on every clock edge, so this block drives a harmless refresh write on every non-write-back cycle.

## Interface
- `INIT_VALUE`, 8'h00, value written to all 16 registers during the post-reset sweep
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: synchronous, active-high reset
- `instr` in 16: instruction, sampled on handshake; fields are `[15:12]` opcode, `[11:8]` rd, `[7:4]` ra, `[3:0]` rb, `[7:0]` imm8
- `instr_valid` in 1: `instr` is valid
- `instr_ready` out 1: block can accept an instruction
- `rf_A`, `rf_B` in 8: combinational read data from the register file
- `rf_A_sel`, `rf_B_sel` out 4: read selects
- `rf_replaceSel` out 4: write select, presented every cycle
- `rf_replaceData` out 8: write data, presented every cycle
- `result` out 8: last computed value
- `zero`, `carry` out 1: ALU flags
- `done` out 1: one-cycle pulse per retired instruction
- `err` out 1: one-cycle pulse with `done` for an illegal opcode
- `busy` out 1: high in any state other than IDLE

## Operation
- **States:** INIT, IDLE, READ, EXEC, WRITE.
- **INIT:**
  - 4-bit counter `cnt` drives `rf_replaceSel=cnt` and `rf_replaceData=INIT_VALUE`.
  - Lasts 16 cycles, covering regs 0..15, then goes to IDLE.
  - `instr_ready=0` throughout.
- **IDLE:**
  - `instr_ready=1`.
  - On `instr_valid`, latch `instr` and go to READ.
  - Otherwise stay in IDLE.
- **READ:**
  - Drive `rf_A_sel=ra` and `rf_B_sel=rb`.
  - Capture `rf_A`/`rf_B` into `op_a`/`op_b` at the edge, then go to EXEC.
- **EXEC:**
  - Compute `alu_out` from `op_a`/`op_b`.
  - At the edge, register `alu_out` into `result`.
  - Update flags for the ALU group only, then go to WRITE.
- **WRITE:**
  - For writing opcodes, drive `rf_replaceSel=rd` and `rf_replaceData=result`.
  - `done=1`. `err=1` if the opcode is illegal.
  - Next state is IDLE.
- **Refresh rule:**
  - Applies to every cycle outside INIT and outside a writing WRITE.
  - Drive `rf_replaceSel=rf_A_sel` and `rf_replaceData=rf_A`.
  - Effect: the register is rewritten with its own value.
  - In IDLE and EXEC, `rf_A_sel` holds its last value; it is 0 after reset.
- **Opcodes (8-bit, wrap-around arithmetic):**
  - 0 NOP: no write.
  - 1 ADD: carry = bit 8 of the sum.
  - 2 SUB: `op_a-op_b`; carry = borrow (`op_a<op_b`).
  - 3 AND, 4 OR, 5 XOR: carry=0.
  - 6 LOADI: `rd←imm8`.
  - 7 MOV: `rd←op_a`.
  - 8 SHL: `op_a<<1`; carry = `op_a[7]`.
  - 9 SHR: logical `op_a>>1`; carry = `op_a[0]`.
  - 10–15: illegal; no write, flags and `result` unchanged.
- **Flags:**
  - `zero` = (`alu_out==0`) for opcodes 1–5 and 8–9 only.
  - LOADI and MOV update `result` but not the flags.
- **`rd==ra` or `rd==rb`:** allowed, because operands are already captured in READ.

## Timing
- **Reset values:**
  - State INIT, `cnt=0`.
  - `instr_ready=0`, `busy=1`, `done=0`, `err=0`.
  - `result=0`, `zero=0`, `carry=0`.
  - `rf_A_sel=rf_B_sel=0`, `rf_replaceSel=0`, `rf_replaceData=INIT_VALUE`.
- **First accept:** `instr_ready` first rises in the 17th cycle after `rst` deasserts.
- **Instruction timing:**
  - Handshake in cycle t.
  - READ in t+1, EXEC in t+2, WRITE with `done` in t+3.
  - The register is updated at the end of t+3.
  - `instr_ready` is high again in t+4.
  - Peak throughput is 1 instruction per 4 cycles.
- **No-write opcodes:** NOP and illegal opcodes still take the full 4 cycles.
- **Result visibility:** `result` and the flags are visible from t+3.
- **`rst` asserted in any state:** the next state is INIT.
  - The in-flight instruction is dropped, with no `done`.
  - The sweep restarts at reg 0.
- **Handshake hold:** `instr_valid` may drop without acceptance while `instr_ready=0`; the block has no combinational path from `instr_valid` to `instr_ready`.

## Structure
- **Package `seq_pkg`:**
  - Opcode constants `OP_NOP`..`OP_SHR`.
  - State enum/localparams.
  - Field slice positions.
- **Sub-module `seq_alu`:** combinational.
  - Inputs: opcode, a, b, imm8.
  - Outputs: y[7:0], c, z, `writes_rd`, `sets_flags`, `illegal`.
- **Top module:** holds the FSM, INIT counter, instruction/operand registers and the refresh mux.

## Test plan
- **Reset sweep:** preload the regfile with 8'hAA, pulse `rst`, then let INIT run. Expect all 16 regs =8'h00, `instr_ready` rising exactly 16 cycles after `rst` falls, and no `done`.
- **Load/add:** issue LOADI r1,8'hF0, then LOADI r2,8'h20, then ADD r3,r1,r2. Expect r3=8'h10, `carry=1`, `zero=0`, and exactly 3 `done` pulses, each 3 cycles after its handshake.
- **Flags and aliasing:** after r1=8'h05, issue SUB r4,r1,r1. Expect r4=0, `zero=1`, `carry=0`. Then SHL r1,r1 expects r1=8'h0A in place.
- **Refresh integrity:** after programming regs 0..15 with distinct values, hold `instr_valid=0` for 100 cycles and issue NOPs. Expect all registers unchanged.
- **Illegal opcode:** issue `instr`=16'hF123. Expect `err` and `done` together in t+3, no register change, and `result`/flags unchanged.
- **Mid-op reset:** assert `rst` in the EXEC cycle of ADD r5,... Expect r5 unchanged before the sweep, no `done`, the state back in INIT, and all regs = INIT_VALUE after 16 cycles.
